// File: rtl/mem_pkg.sv
// Shared types and constants for the 8x8 memory system initiator.
// State encoding covers the optional readback phases (MEM_ACCESS_MASTER_READBACK_EN).
package mem_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int TIMER_W    = 4;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_RESP   = 3'd2,
        ST_GAP    = 3'd3,
        ST_VERIFY = 3'd4
    } state_e;

endpackage

// File: rtl/mem_access_master_if.sv
// Host command/response handshake plus memory-system pin bundle.
// The master modport is the initiator's view; slave is the host/memory side.
interface mem_access_master_if
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              mem_op;
    logic              mem_select;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, mem_data_out,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_op, mem_select, mem_address, mem_data_in
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, mem_data_out,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_op, mem_select, mem_address, mem_data_in
    );
endinterface

// File: rtl/mem_access_timer.sv
// Access-phase down-counter: loads CYCLES-1, counts to zero, flags done at zero.
module mem_access_timer
    import mem_pkg::*;
#(
    parameter int unsigned CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);
    logic [TIMER_W-1:0] count_q;

    // NOTE: sequential state uses <= so every flop samples pre-edge values in parallel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= TIMER_W'(CYCLES - 1);
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - TIMER_W'(1);
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/mem_access_master.sv
// Single-outstanding initiator driving the memory pins with ACCESS_CYCLES hold time.
// Define MEM_ACCESS_MASTER_READBACK_EN to add a verify read after every write.
module mem_access_master
    import mem_pkg::*;
#(
    parameter int          DATA_W        = DATA_W_DEF,
    parameter int          ADDR_W        = ADDR_W_DEF,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    mem_access_master_if.master bus
);
    state_e            state_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              mem_op_q;
    logic              mem_select_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [DATA_W-1:0] mem_data_in_q;
`ifdef MEM_ACCESS_MASTER_READBACK_EN
    logic              rsp_err_q;
`endif

    logic timer_load;
    logic timer_en;
    logic timer_done;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        timer_load = 1'b0;
        timer_en   = 1'b0;
        if (state_q == ST_IDLE && bus.cmd_valid) timer_load = 1'b1;
        if (state_q == ST_GAP)                   timer_load = 1'b1;
        if (state_q == ST_ACCESS || state_q == ST_VERIFY) timer_en = 1'b1;
    end

    mem_access_timer #(.CYCLES(ACCESS_CYCLES)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (timer_load),
        .en_i   (timer_en),
        .done_o (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            mem_op_q      <= OP_READ;
            mem_select_q  <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
`ifdef MEM_ACCESS_MASTER_READBACK_EN
            rsp_err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        mem_op_q      <= bus.cmd_op;
                        mem_address_q <= bus.cmd_addr;
                        mem_data_in_q <= bus.cmd_wdata;
                        mem_select_q  <= 1'b1;
                        cmd_ready_q   <= 1'b0;
                        state_q       <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (timer_done) begin
                        mem_select_q <= 1'b0;
`ifdef MEM_ACCESS_MASTER_READBACK_EN
                        if (mem_op_q == OP_WRITE) begin
                            state_q <= ST_GAP;
                        end else begin
                            rsp_rdata_q <= bus.mem_data_out;
                            rsp_err_q   <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end
`else
                        if (mem_op_q == OP_READ) rsp_rdata_q <= bus.mem_data_out;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
`endif
                    end
                end
`ifdef MEM_ACCESS_MASTER_READBACK_EN
                // One idle cycle lets the memory FSM return to idle before the verify read.
                ST_GAP: begin
                    mem_op_q     <= OP_READ;
                    mem_select_q <= 1'b1;
                    state_q      <= ST_VERIFY;
                end
                ST_VERIFY: begin
                    if (timer_done) begin
                        mem_select_q <= 1'b0;
                        rsp_rdata_q  <= bus.mem_data_out;
                        rsp_err_q    <= (bus.mem_data_out != mem_data_in_q);
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
`endif
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.mem_op      = mem_op_q;
    assign bus.mem_select  = mem_select_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data_in = mem_data_in_q;
`ifdef MEM_ACCESS_MASTER_READBACK_EN
    assign bus.rsp_err     = rsp_err_q;
`else
    assign bus.rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master with a behavioural 8x8 memory and a response scoreboard.
// Honours MEM_ACCESS_MASTER_READBACK_EN for expected latency and readback results.
module tb_mem_access_master;
    import mem_pkg::*;

    localparam int unsigned AC = 2;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic force_zero = 1'b0;

    logic [7:0] mem_arr [8];
    logic [7:0] ref_mem [8];
    logic [7:0] last_rdata;
    exp_t       sb [$];

    int checks = 0;
    int errors = 0;

    mem_access_master_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    mem_access_master #(.DATA_W(8), .ADDR_W(3), .ACCESS_CYCLES(AC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Behavioural memory system; force_zero corrupts read data to exercise readback errors.
    always @(posedge clk) begin
        if (bus.mem_select && bus.mem_op == OP_WRITE) mem_arr[bus.mem_address] <= bus.mem_data_in;
    end
    assign bus.mem_data_out = (bus.mem_select && bus.mem_op == OP_READ && !force_zero)
                              ? mem_arr[bus.mem_address] : 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic op, input logic [2:0] addr, input logic [7:0] wdata);
        exp_t e;
        int   n;
        int   sel;
        int   exp_lat;
        int   exp_sel;
        exp_lat = AC;
        exp_sel = AC;
        e.err   = 1'b0;
        if (op == OP_READ) begin
            e.rdata = ref_mem[addr];
        end else begin
            ref_mem[addr] = wdata;
`ifdef MEM_ACCESS_MASTER_READBACK_EN
            e.rdata = force_zero ? 8'h00 : wdata;
            e.err   = force_zero;
            exp_lat = 2 * AC + 1;
            exp_sel = 2 * AC;
`else
            e.rdata = last_rdata;
`endif
        end
        last_rdata = e.rdata;
        sb.push_back(e);

        check("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = ~op;
        bus.cmd_addr  = addr + 3'd1;
        bus.cmd_wdata = ~wdata;
        check("acc_address", bus.mem_address, addr);
        check("acc_op", bus.mem_op, op);
        check("acc_data_in", bus.mem_data_in, wdata);
        check("acc_cmd_ready", bus.cmd_ready, 0);

        n   = 0;
        sel = 0;
        while (!bus.rsp_valid && n < 40) begin
            if (bus.mem_select) sel++;
            @(negedge clk);
            n++;
        end
        check("rsp_latency", n, exp_lat);
        check("select_cycles", sel, exp_sel);
    endtask

    task automatic take_rsp();
        exp_t e;
        check("rsp_valid", bus.rsp_valid, 1);
        check("sb_pending", 32'(sb.size()), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            check("rsp_err", bus.rsp_err, e.err);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_dropped", bus.rsp_valid, 0);
        check("cmd_ready_back", bus.cmd_ready, 1);
        check("select_low", bus.mem_select, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem_arr[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        last_rdata    = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_READ;
        bus.cmd_addr  = 3'd0;
        bus.cmd_wdata = 8'h00;
        bus.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_select", bus.mem_select, 0);
        check("rst_op", bus.mem_op, 0);
        check("rst_address", bus.mem_address, 0);
        check("rst_data_in", bus.mem_data_in, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write then readback.
        send_cmd(OP_WRITE, 3'd3, 8'hA5);
        take_rsp();
        send_cmd(OP_READ, 3'd3, 8'h00);
        take_rsp();

        // Full address sweep, including the top word.
        for (int k = 0; k < 8; k++) begin
            send_cmd(OP_WRITE, 3'(k), 8'h10 + 8'(k));
            take_rsp();
        end
        for (int k = 0; k < 8; k++) begin
            send_cmd(OP_READ, 3'(k), 8'hEE);
            take_rsp();
        end

        // Backpressure: response held while a new command waits.
        send_cmd(OP_READ, 3'd3, 8'h00);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_WRITE;
        bus.cmd_addr  = 3'd5;
        bus.cmd_wdata = 8'h77;
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_rdata", bus.rsp_rdata, ref_mem[3]);
            check("bp_cmd_ready", bus.cmd_ready, 0);
            check("bp_select", bus.mem_select, 0);
        end
        bus.cmd_valid = 1'b0;
        take_rsp();

        // Reset during ACCESS cycle 1 discards the command.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_READ;
        bus.cmd_addr  = 3'd2;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("mid_select_high", bus.mem_select, 1);
        rst_n = 1'b0;
        #1;
        check("mid_select_drop", bus.mem_select, 0);
        check("mid_rsp_valid", bus.rsp_valid, 0);
        check("mid_rsp_rdata", bus.rsp_rdata, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        last_rdata = 8'h00;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_no_rsp", bus.rsp_valid, 0);
            check("post_rst_cmd_ready", bus.cmd_ready, 1);
        end

        // Address 5 must still hold the sweep value: the held command never issued.
        send_cmd(OP_READ, 3'd5, 8'h00);
        take_rsp();

`ifdef MEM_ACCESS_MASTER_READBACK_EN
        force_zero = 1'b1;
        send_cmd(OP_WRITE, 3'd6, 8'hFF);
        force_zero = 1'b0;
        take_rsp();
`endif

        check("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
